// File: rtl/rw_window_ram.sv
// rw_window_ram: single-port synchronous RAM mapped into a contiguous window
// of the CPU address space. After every reset a hardware clear sequence
// zeroes all words; accesses are ignored while it runs (busy = 1).
module rw_window_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int BASE   = 128,
    parameter int DEPTH  = 96
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rvalid,
    output logic              hit,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Window bounds carry one extra bit so a window ending at 2^ADDR_W does not wrap.
    localparam logic [ADDR_W:0] WIN_LO = (ADDR_W+1)'(BASE);
    localparam logic [ADDR_W:0] WIN_HI = (ADDR_W+1)'(BASE + DEPTH);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Reject window placements that fall outside the address space.
    if (DEPTH < 1 || BASE < 0 ||
        longint'(BASE) + longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_params
        $error("rw_window_ram: illegal BASE/DEPTH for ADDR_W");
    end

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W:0]   addr_ext;
    logic              in_win;
    logic [IDX_W-1:0]  idx;
    logic              acc;
    logic              last_ptr;

    // Address decode, access qualification and status outputs.
    always_comb begin
        addr_ext = {1'b0, address};
        in_win   = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
        idx      = IDX_W'(address - ADDR_W'(BASE));
        busy     = (state_q == ST_CLEAR);
        hit      = in_win && !busy;
        acc      = req && hit;
        last_ptr = (ptr_q == IDX_W'(DEPTH - 1));
    end

    // Next-state logic for the clear FSM and the registered read port.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        ptr_d    = ptr_q;
        data_d   = data_q;
        rvalid_d = 1'b0;
        if (state_q == ST_CLEAR) begin
            if (last_ptr) begin
                state_d = ST_READY;
                ptr_d   = '0;
            end else begin
                ptr_d = ptr_q + IDX_W'(1);
            end
        end else if (acc && !write) begin
            data_d   = mem_q[idx];
            rvalid_d = 1'b1;
        end
    end

    // Control state and read data; reset restarts the clear sequence.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
        if (reset) begin
            state_q  <= ST_CLEAR;
            ptr_q    <= '0;
            data_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            data_q   <= data_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Storage array: zeroed word by word during clear, then written by the CPU.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset term; the clear sequence zeroes it, which keeps it mappable onto RAM macros.
        if (busy) begin
            mem_q[ptr_q] <= '0;
        end else if (acc && write) begin
            mem_q[idx] <= data_in;
        end
    end

    assign data_out = data_q;
    assign rvalid   = rvalid_q;

endmodule

// File: doc/rw_window_ram.md
# rw_window_ram

Parametrised single-port synchronous RAM that occupies a contiguous window of the CPU address space and responds only to addresses inside it. It is the successor to the fixed 96x8 read/write window. It adds configurable width, depth and base address, an explicit access strobe, a registered read-valid pulse, and a hardware clear sequence that zeroes every word after reset. It sits on the 8-bit CPU data bus beside the ROM and I/O decoders.

## Interface

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 8, CPU address width in bits.
- BASE, 128, first address of the window.
- DEPTH, 96, number of words. Legal when DEPTH ≥ 1 and BASE+DEPTH ≤ 2^ADDR_W; anything else is an elaboration error.

Ports:
- clk, input, 1: the only clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- req, input, 1: access strobe, sampled at the rising edge.
- write, input, 1: 1 = write, 0 = read; meaningful only when req = 1.
- address, input, ADDR_W: CPU byte address.
- data_in, input, DATA_W: write data.
- data_out, output, DATA_W: registered read data.
- rvalid, output, 1: one-cycle pulse; data_out holds fresh read data.
- hit, output, 1: combinational; address lies in the window and busy = 0.
- busy, output, 1: clear sequence in progress; all accesses are ignored.

## Operation

- **Window decode.** in_win = (address ≥ BASE) && (address < BASE+DEPTH). The compare is evaluated at ADDR_W+1 bits so BASE+DEPTH = 2^ADDR_W does not wrap.
- **Index.** Word index = address − BASE, truncated to clog2(DEPTH) bits. The top window address maps to index DEPTH−1.
- **Access qualifier.** acc = req && in_win && !busy. hit = in_win && !busy.
- **States.** The FSM has two states, CLEAR and READY.
  - Reset sends the FSM to CLEAR with clear pointer = 0.
  - In CLEAR, each edge writes 0 to mem[ptr] and increments ptr.
  - On the edge that writes index DEPTH−1, the FSM moves to READY.
  - READY is left only by reset.
- **Write.** On acc && write, mem[index] <= data_in. data_out is unchanged and rvalid = 0.
- **Read.** On acc && !write, data_out <= mem[index] (the value before any write on the same edge) and rvalid <= 1. On every other edge, rvalid <= 0.
- **Ignored requests.** A request outside the window, or any request while busy, has no effect: memory, data_out and rvalid do not change. It is not buffered or replayed; the requester must retry once busy is low.
- **Read-after-write.** A read of an address written on the previous edge returns the new data.
- **Single port.** Only one access happens per edge, so read and write cannot collide.

## Timing

- **Reset values (asynchronous, applied immediately):**
  - data_out = 0, rvalid = 0, busy = 1, ptr = 0, state = CLEAR.
  - Memory contents are not reset directly; the clear sequence zeroes them.
- **Clear duration.** busy stays high through exactly DEPTH rising edges after reset deasserts. It falls after edge DEPTH; the first access can be accepted on edge DEPTH+1.
- **Reset during the clear sequence.** The sequence restarts from ptr = 0 and the full DEPTH-edge duration applies again.
- **Reset during READY.** data_out and rvalid clear at once, then the clear sequence runs.
- **Read latency.** Address is presented with req at edge N. data_out is valid and rvalid = 1 after edge N. rvalid falls after edge N+1 unless another read is accepted at N+1.
- **Throughput.** Back-to-back reads give rvalid held high, with data_out updating every cycle.
- **Write latency.** The write is visible to a read accepted on the next edge.
- **hit** is combinational from address and busy, with no added latency.

## Test plan

- **Clear sequence.** Assert reset, release, and count edges: busy = 1 for exactly 96 edges. Then read 128, 175 and 223: each returns 0x00 with rvalid = 1 one cycle after its request.
- **Write/read round trip.** After the clear, write 0xA5 to 128, 0x3C to 223 and 0xFF to 200, then read them back to back. Required: data_out = 0xA5, 0x3C, 0xFF on consecutive cycles with rvalid held high.
- **Out-of-window requests.** Write 0x77 to 127 and 224, then read 127, 0 and 255. Required: hit = 0, rvalid stays 0, data_out keeps its previous value, and a read of 128 still returns 0xA5.
- **Request during clear.** Write 0x55 to 150 at edge 10 after reset release. Required: ignored; after busy falls, a read of 150 returns 0x00.
- **Reset mid-clear.** Reassert reset at edge 50 of the clear. Required: busy stays high for a further full 96 edges after release, and data_out = 0 while reset is held.
- **Parameter variant.** Instantiate DATA_W = 16, BASE = 0xF0, DEPTH = 16 (window ends at 2^8). Write 0xBEEF to 0xFF and read it back to get 0xBEEF. Address 0xEF gives hit = 0, and the clear runs for 16 edges.
